// File: rtl/sp_ram_sync_if.sv
// Bus bundle for sp_ram_sync: write enable, shared address, write data and registered read data.
// With PARITY_CHECK_EN defined the bundle also carries the registered parity_err flag.
interface sp_ram_sync_if #(
    parameter int data_width = 8,
    parameter int addr_width = 4
) ();
    logic                  we;
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] data_in;
    logic [data_width-1:0] data_out;
`ifdef PARITY_CHECK_EN
    logic                  parity_err;

    modport master (
        output we, addr, data_in,
        input  data_out, parity_err
    );

    modport slave (
        input  we, addr, data_in,
        output data_out, parity_err
    );
`else
    modport master (
        output we, addr, data_in,
        input  data_out
    );

    modport slave (
        input  we, addr, data_in,
        output data_out
    );
`endif
endinterface

// File: rtl/sp_ram_sync.sv
// Single-port synchronous RAM, registered read, write-first; the array itself is never reset.
// Optional macro PARITY_CHECK_EN stores an even-parity bit per word and flags mismatches on read.
module sp_ram_sync #(
    parameter int data_width = 8,
    parameter int addr_width = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    sp_ram_sync_if.slave bus
);
    localparam int depth = 2 ** addr_width;
`ifdef PARITY_CHECK_EN
    localparam int word_width = data_width + 1;
`else
    localparam int word_width = data_width;
`endif

    logic [word_width-1:0] mem [depth];
    logic [word_width-1:0] wr_word;

    always_comb begin
`ifdef PARITY_CHECK_EN
        wr_word = {^bus.data_in, bus.data_in};
`else
        wr_word = bus.data_in;
`endif
    end

    // No reset on the array so it maps onto RAM primitives; writes are blocked during reset.
    always_ff @(posedge clk) begin
        if (rst_n && bus.we) begin
            mem[bus.addr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_out <= '0;
        end else if (bus.we) begin
            bus.data_out <= bus.data_in;
        end else begin
            bus.data_out <= mem[bus.addr][data_width-1:0];
        end
    end

`ifdef PARITY_CHECK_EN
    // A stored word with even parity XORs to zero across all bits, data plus parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.parity_err <= 1'b0;
        end else if (bus.we) begin
            bus.parity_err <= 1'b0;
        end else begin
            bus.parity_err <= ^mem[bus.addr];
        end
    end
`endif
endmodule

// File: tb/tb_sp_ram_sync.sv
// Directed bench for sp_ram_sync: reset, write-through, sweep, boundary and reset-during-write checks.
// The parity section is compiled only when PARITY_CHECK_EN is defined.
module tb_sp_ram_sync;
    localparam int data_width = 8;
    localparam int addr_width = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    sp_ram_sync_if #(.data_width(data_width), .addr_width(addr_width)) bus ();

    sp_ram_sync #(.data_width(data_width), .addr_width(addr_width)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [data_width-1:0] observed,
                         input logic [data_width-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic cycle(input logic w, input logic [addr_width-1:0] a,
                         input logic [data_width-1:0] d);
        @(negedge clk);
        bus.we      = w;
        bus.addr    = a;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    logic [addr_width-1:0] sweep_addr [7];
    logic [data_width-1:0] sweep_data [7];

    initial begin
        vectors     = 0;
        miscompares = 0;
        sweep_addr  = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        sweep_data  = '{8'h7E, 8'hA1, 8'hD5, 8'h38, 8'h75, 8'hA9, 8'h85};

        rst_n       = 1'b0;
        bus.we      = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;
        #1;
        check("reset_initial", bus.data_out, 8'h00);
        cycle(1'b0, 4'd0, 8'h00);
        check("reset_held", bus.data_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        cycle(1'b1, 4'd0, 8'h3C);
        check("wr0_through", bus.data_out, 8'h3C);
        cycle(1'b0, 4'd0, 8'h00);
        check("rd0", bus.data_out, 8'h3C);

        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, sweep_addr[i], sweep_data[i]);
            check("sweep_wr", bus.data_out, sweep_data[i]);
            cycle(1'b0, sweep_addr[i], 8'h00);
            check("sweep_rd", bus.data_out, sweep_data[i]);
        end
        for (int i = 6; i >= 0; i--) begin
            cycle(1'b0, sweep_addr[i], 8'h00);
            check("sweep_rev_rd", bus.data_out, sweep_data[i]);
        end
        cycle(1'b0, 4'd0, 8'h00);
        check("rd0_after_sweep", bus.data_out, 8'h3C);

        cycle(1'b1, 4'd15, 8'hFF);
        check("wr15_through", bus.data_out, 8'hFF);
        cycle(1'b1, 4'd0, 8'h01);
        check("wr0_b_through", bus.data_out, 8'h01);
        cycle(1'b0, 4'd15, 8'h00);
        check("rd15", bus.data_out, 8'hFF);
        cycle(1'b0, 4'd0, 8'h00);
        check("rd0_b", bus.data_out, 8'h01);
        cycle(1'b1, 4'd15, 8'h00);
        cycle(1'b1, 4'd15, 8'h00);
        cycle(1'b0, 4'd4, 8'h00);
        check("rd4_between", bus.data_out, 8'hD5);
        cycle(1'b0, 4'd15, 8'h00);
        check("rd15_overwritten", bus.data_out, 8'h00);
        cycle(1'b1, 4'd2, 8'h11);
        cycle(1'b1, 4'd2, 8'h22);
        cycle(1'b0, 4'd2, 8'h00);
        check("last_write_wins", bus.data_out, 8'h22);

        cycle(1'b0, 4'd3, 8'h00);
        check("rd3_pre_reset", bus.data_out, 8'hA1);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.we      = 1'b1;
        bus.addr    = 4'd3;
        bus.data_in = 8'h55;
        #1;
        check("async_clear", bus.data_out, 8'h00);
        @(posedge clk);
        #1;
        check("clear_held_edge", bus.data_out, 8'h00);
        @(negedge clk);
        rst_n  = 1'b1;
        bus.we = 1'b0;
        cycle(1'b0, 4'd3, 8'h00);
        check("rd3_after_reset", bus.data_out, 8'hA1);
        cycle(1'b0, 4'd8, 8'h00);
        check("rd8_after_reset", bus.data_out, 8'h85);

`ifdef PARITY_CHECK_EN
        cycle(1'b1, 4'd0, 8'h3C);
        check("par_wr_flag", {7'd0, bus.parity_err}, 8'h00);
        cycle(1'b0, 4'd0, 8'h00);
        check("par_rd_data", bus.data_out, 8'h3C);
        check("par_rd_flag", {7'd0, bus.parity_err}, 8'h00);
        @(negedge clk);
        dut.mem[0][data_width] = ~dut.mem[0][data_width];
        cycle(1'b0, 4'd0, 8'h00);
        check("par_corrupt_flag", {7'd0, bus.parity_err}, 8'h01);
        cycle(1'b0, 4'd1, 8'h00);
        check("par_clean_flag", {7'd0, bus.parity_err}, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sp_ram_sync.md
Name: sp_ram_sync

Overview:
- Single-port synchronous RAM, depth 2**addr_width, width data_width; one shared address bus for read and write.
- Registered read, write-first on simultaneous access.
- General-purpose storage macro: register files, small lookup/scratch buffers in datapath blocks.
- Behavioural array; must infer block/distributed RAM, so reset never touches the array.

Parameters:
- data_width, 8, word width in bits (>=1).
- addr_width, 4, address width in bits (>=1); depth = 2**addr_width words (default 16).

Ports:
- clk  input  1  system clock; all sampling on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- we  input  1  write enable; 1 = write data_in to mem[addr] this edge, 0 = read.
- addr  input  addr_width  word address, shared by read and write.
- data_in  input  data_width  write data.
- data_out  output  data_width  registered read data.

Behaviour:
- Reset: rst_n low asynchronously forces data_out to 0; held 0 while rst_n low; memory array unchanged (not cleared, no per-word reset).
- Writes ignored while rst_n low; first active edge is the first rising clk with rst_n high.
- Write (we=1 at rising edge): mem[addr] <= data_in; same edge data_out <= data_in (write-first / write-through).
- Read (we=0 at rising edge): data_out <= mem[addr]; latency one clock (value visible after the edge where addr is sampled).
- data_out holds its value between edges; no combinational path from addr/data_in to data_out.
- Full address range valid; no out-of-range case (depth exactly 2**addr_width); no wrap logic needed.
- Unwritten locations read X in simulation (no initialization); benches must write before read.
- Back-to-back: write addr A at edge n, read A at edge n+1 returns the new data.
- Consecutive writes to the same address: last write wins.
- Reset asserted mid-operation: data_out clears immediately; a write on the same edge as reset assertion is discarded; previously written contents preserved and readable after release.

Optional Feature:
- Macro PARITY_CHECK_EN.
- Defined: each word stored with one extra even-parity bit (XOR of data_in) computed on write; extra output parity_err (1 bit, registered, reset 0) updates on every read edge: 1 if stored parity mismatches XOR of stored data, 0 otherwise; on write edges parity_err <= 0. Array width becomes data_width+1.
- Not defined: no parity storage, no parity_err port; behaviour otherwise identical.

Test Plan:
- Reset: rst_n=0 with data_out previously 0xA1 -> data_out=0x00 immediately, without waiting for a clock edge; release rst_n, read unchanged contents.
- Write/read addr 0: we=1 addr=0 data_in=0x3C one edge -> data_out=0x3C (write-through); next edge we=0 addr=0 -> data_out=0x3C.
- Sweep: write 0x7E@1, 0xA1@3, 0xD5@4, 0x38@5, 0x75@6, 0xA9@7, 0x85@8, each followed by a read -> each read returns the written value one cycle later; then re-read all in reverse order -> same values, no aliasing.
- Boundary: write 0xFF@15 and 0x01@0, read 15 then 0 -> 0xFF, 0x01; overwrite addr 15 with 0x00 twice -> read 0x00.
- Reset mid-write: assert rst_n=0 coincident with we=1 addr=3 data_in=0x55 -> after release, read addr 3 returns 0xA1.
- PARITY_CHECK_EN: normal write/read 0x3C -> parity_err=0; force-corrupt stored parity bit via hierarchical deposit, read -> parity_err=1 one cycle after read edge.
